// File: rtl/text_console_writer.sv
// text_console_writer: turns a character byte stream into TextGraphic text
// buffer writes with terminal-style cursor handling (CR, LF, BS, FF, wrap).
//
// Ports:
//   clk50, rst_n           clock (also the buffer WClk), async active-low reset
//   ch_data/fg/bg/bl       character code and its attributes
//   ch_valid, ch_ready     accept handshake (accepted when both high on an edge)
//   WAddr, WData, Write    text buffer write port, cell = {bl, bg, fg, char}
//   cursor_row/col         current cursor position
//   busy                   a multi-cycle line or screen clear is running
module text_console_writer #(
  parameter int unsigned COLS   = 120,
  parameter int unsigned ROWS   = 60,
  parameter int unsigned ADDR_W = 13
) (
  input  logic              clk50,
  input  logic              rst_n,
  input  logic [7:0]        ch_data,
  input  logic [3:0]        ch_fg,
  input  logic [3:0]        ch_bg,
  input  logic [1:0]        ch_bl,
  input  logic              ch_valid,
  output logic              ch_ready,
  output logic [ADDR_W-1:0] WAddr,
  output logic [17:0]       WData,
  output logic              Write,
  output logic [5:0]        cursor_row,
  output logic [6:0]        cursor_col,
  output logic              busy
);

  localparam int unsigned ROW_W  = 6;
  localparam int unsigned COL_W  = 7;
  localparam int unsigned ATTR_W = 10;

  localparam logic [ADDR_W-1:0] LAST_ADDR    = ADDR_W'(COLS * ROWS - 1);
  localparam logic [ADDR_W-1:0] COLS_A       = ADDR_W'(COLS);
  localparam logic [COL_W-1:0]  LAST_COL     = COL_W'(COLS - 1);
  localparam logic [ROW_W-1:0]  LAST_ROW     = ROW_W'(ROWS - 1);
  localparam logic [ATTR_W-1:0] DEFAULT_ATTR = {2'b00, 4'h0, 4'hF};
  localparam logic [7:0]        SPACE        = 8'h20;

  typedef enum logic [1:0] {
    S_CLR_SCR,
    S_IDLE,
    S_PUT,
    S_CLR_LINE
  } state_t;

  state_t              state, state_d;
  logic [ROW_W-1:0]    row_d, row_inc;
  logic [COL_W-1:0]    col_d;
  logic [ADDR_W-1:0]   row_base, row_base_d, base_inc;
  logic [ADDR_W-1:0]   clr_addr, clr_addr_d;
  logic [COL_W-1:0]    clr_col, clr_col_d;
  logic [ATTR_W-1:0]   attr, attr_d;
  logic [7:0]          chr, chr_d;
  logic [ADDR_W-1:0]   waddr_d;
  logic [17:0]         wdata_d;
  logic                write_d, ready_d, busy_d;

  // State and registered outputs
  always_ff @(posedge clk50 or negedge rst_n) begin
    if (!rst_n) begin
      state      <= S_CLR_SCR;
      cursor_row <= '0;
      cursor_col <= '0;
      row_base   <= '0;
      clr_addr   <= '0;
      clr_col    <= '0;
      attr       <= DEFAULT_ATTR;
      chr        <= '0;
      WAddr      <= '0;
      WData      <= '0;
      Write      <= 1'b0;
      ch_ready   <= 1'b0;
      busy       <= 1'b0;
    end else begin
      state      <= state_d;
      cursor_row <= row_d;
      cursor_col <= col_d;
      row_base   <= row_base_d;
      clr_addr   <= clr_addr_d;
      clr_col    <= clr_col_d;
      attr       <= attr_d;
      chr        <= chr_d;
      WAddr      <= waddr_d;
      WData      <= wdata_d;
      Write      <= write_d;
      ch_ready   <= ready_d;
      busy       <= busy_d;
    end
  end

  // Next-state, cursor arithmetic and next output values
  always_comb begin
    state_d    = state;
    row_d      = cursor_row;
    col_d      = cursor_col;
    row_base_d = row_base;
    clr_addr_d = clr_addr;
    clr_col_d  = clr_col;
    attr_d     = attr;
    chr_d      = chr;
    waddr_d    = WAddr;
    wdata_d    = WData;
    write_d    = 1'b0;

    // Next line wraps to row 0 without scrolling; base tracks row*COLS.
    if (cursor_row == LAST_ROW) begin
      row_inc  = '0;
      base_inc = '0;
    end else begin
      row_inc  = cursor_row + ROW_W'(1);
      base_inc = row_base + COLS_A;
    end

    case (state)
      S_CLR_SCR: begin
        write_d    = 1'b1;
        waddr_d    = clr_addr;
        wdata_d    = {attr, SPACE};
        clr_addr_d = clr_addr + ADDR_W'(1);
        if (clr_addr == LAST_ADDR) begin
          state_d    = S_IDLE;
          row_d      = '0;
          col_d      = '0;
          row_base_d = '0;
          clr_addr_d = '0;
        end
      end

      S_IDLE: begin
        if (ch_valid && ch_ready) begin
          attr_d = {ch_bl, ch_bg, ch_fg};
          chr_d  = ch_data;
          case (ch_data)
            8'h0D: col_d = '0;
            8'h0A: begin
              col_d      = '0;
              row_d      = row_inc;
              row_base_d = base_inc;
              clr_col_d  = '0;
              state_d    = S_CLR_LINE;
            end
            8'h08: begin
              if (cursor_col != '0) col_d = cursor_col - COL_W'(1);
            end
            8'h0C: begin
              clr_addr_d = '0;
              state_d    = S_CLR_SCR;
            end
            // Other control codes are swallowed; 0x20 and up are printed.
            default: begin
              if (ch_data[7:5] != 3'b000) state_d = S_PUT;
            end
          endcase
        end
      end

      S_PUT: begin
        write_d = 1'b1;
        waddr_d = row_base + ADDR_W'(cursor_col);
        wdata_d = {attr, chr};
        if (cursor_col == LAST_COL) begin
          col_d      = '0;
          row_d      = row_inc;
          row_base_d = base_inc;
          clr_col_d  = '0;
          state_d    = S_CLR_LINE;
        end else begin
          col_d   = cursor_col + COL_W'(1);
          state_d = S_IDLE;
        end
      end

      S_CLR_LINE: begin
        write_d   = 1'b1;
        waddr_d   = row_base + ADDR_W'(clr_col);
        wdata_d   = {attr, SPACE};
        clr_col_d = clr_col + COL_W'(1);
        if (clr_col == LAST_COL) state_d = S_IDLE;
      end

      default: state_d = S_IDLE;
    endcase

    ready_d = (state_d == S_IDLE);
    busy_d  = (state_d == S_CLR_SCR) || (state_d == S_CLR_LINE);
  end

endmodule

// File: tb/tb_text_console_writer.sv
// Bench for text_console_writer: vector table, hand sequences for the
// multi-cycle cases, and random text against a cursor/screen write model.
module tb_text_console_writer;

  localparam int COLS  = 120;
  localparam int ROWS  = 60;
  localparam int CELLS = COLS * ROWS;
  localparam int LIMIT = 20000;

  logic        clk50;
  logic        rst_n;
  logic [7:0]  ch_data;
  logic [3:0]  ch_fg, ch_bg;
  logic [1:0]  ch_bl;
  logic        ch_valid;
  logic        ch_ready;
  logic [12:0] WAddr;
  logic [17:0] WData;
  logic        Write;
  logic [5:0]  cursor_row;
  logic [6:0]  cursor_col;
  logic        busy;

  text_console_writer dut (
    .clk50(clk50), .rst_n(rst_n),
    .ch_data(ch_data), .ch_fg(ch_fg), .ch_bg(ch_bg), .ch_bl(ch_bl),
    .ch_valid(ch_valid), .ch_ready(ch_ready),
    .WAddr(WAddr), .WData(WData), .Write(Write),
    .cursor_row(cursor_row), .cursor_col(cursor_col), .busy(busy)
  );

  initial clk50 = 1'b0;
  always #5 clk50 = ~clk50;

  typedef struct packed {
    logic [12:0] addr;
    logic [17:0] data;
  } wr_t;

  typedef struct packed {
    logic [7:0]  ch;
    logic [3:0]  fg;
    logic [3:0]  bg;
    logic [1:0]  bl;
    logic        wr;
    logic [12:0] addr;
    logic [17:0] data;
    logic [5:0]  row;
    logic [6:0]  col;
  } vec_t;

  wr_t  exp_q[$];
  vec_t vecs[8];
  int   total = 0;
  int   bad   = 0;
  int   mrow  = 0;
  int   mcol  = 0;
  int   wcnt  = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // Every sample point goes through here so each write is checked once.
  task automatic tick();
    wr_t e;
    @(negedge clk50);
    if (rst_n && Write) begin
      wcnt++;
      if (exp_q.size() == 0) begin
        chk("unexpected_write", 32'(WAddr), 32'hFFFF_FFFF);
      end else begin
        e = exp_q.pop_front();
        chk("waddr", 32'(WAddr), 32'(e.addr));
        chk("wdata", 32'(WData), 32'(e.data));
      end
    end
  endtask

  task automatic push_line(input int row, input logic [9:0] a);
    for (int c = 0; c < COLS; c++) exp_q.push_back({13'(row * COLS + c), a, 8'h20});
  endtask

  task automatic push_screen(input logic [9:0] a);
    for (int i = 0; i < CELLS; i++) exp_q.push_back({13'(i), a, 8'h20});
  endtask

  // Reference: terminal semantics on an accepted character.
  task automatic model_accept(input logic [7:0] c, input logic [9:0] a);
    if (c == 8'h0D) begin
      mcol = 0;
    end else if (c == 8'h0A) begin
      mcol = 0;
      mrow = (mrow + 1) % ROWS;
      push_line(mrow, a);
    end else if (c == 8'h08) begin
      if (mcol > 0) mcol--;
    end else if (c == 8'h0C) begin
      push_screen(a);
      mrow = 0;
      mcol = 0;
    end else if (c >= 8'h20) begin
      exp_q.push_back({13'(mrow * COLS + mcol), a, c});
      mcol++;
      if (mcol == COLS) begin
        mcol = 0;
        mrow = (mrow + 1) % ROWS;
        push_line(mrow, a);
      end
    end
  endtask

  // Returns just after the accepting rising edge.
  task automatic send(input logic [7:0] c, input logic [3:0] fg, input logic [3:0] bg,
                      input logic [1:0] bl);
    int n;
    tick();
    ch_data  = c;
    ch_fg    = fg;
    ch_bg    = bg;
    ch_bl    = bl;
    ch_valid = 1'b1;
    n = 0;
    while (!ch_ready && n < LIMIT) begin
      tick();
      n++;
    end
    if (!ch_ready) begin
      chk("send_timeout", 32'd0, 32'd1);
      ch_valid = 1'b0;
    end else begin
      @(posedge clk50);
      model_accept(c, {bl, bg, fg});
      #1 ch_valid = 1'b0;
    end
  endtask

  task automatic wait_idle(output int n);
    n = 0;
    while (!(ch_ready && exp_q.size() == 0) && n < LIMIT) begin
      tick();
      n++;
    end
    if (!(ch_ready && exp_q.size() == 0)) chk("idle_timeout", 32'(exp_q.size()), 32'd0);
  endtask

  task automatic chk_cursor(input string nm);
    chk({nm, "_row"}, 32'(cursor_row), 32'(mrow));
    chk({nm, "_col"}, 32'(cursor_col), 32'(mcol));
  endtask

  function automatic logic [7:0] rand_char();
    int r;
    r = $urandom_range(0, 99);
    if (r < 70)      return 8'(8'h20 + $urandom_range(0, 223));
    else if (r < 78) return 8'h0D;
    else if (r < 84) return 8'h0A;
    else if (r < 94) return 8'h08;
    else             return 8'($urandom_range(0, 4) * 7);
  endfunction

  initial begin
    int n, w0, low;
    logic [7:0] c;

    rst_n = 1'b0; ch_valid = 1'b0; ch_data = '0; ch_fg = '0; ch_bg = '0; ch_bl = '0;

    vecs[0] = '{8'h48, 4'hA, 4'h1, 2'd0, 1'b1, 13'd0, 18'h01A48, 6'd0, 7'd1};
    vecs[1] = '{8'h0D, 4'h3, 4'h3, 2'd1, 1'b0, 13'd0, 18'h00000, 6'd0, 7'd0};
    vecs[2] = '{8'h65, 4'h3, 4'h2, 2'd2, 1'b1, 13'd0, 18'h22365, 6'd0, 7'd1};
    vecs[3] = '{8'h08, 4'h0, 4'h0, 2'd0, 1'b0, 13'd0, 18'h00000, 6'd0, 7'd0};
    vecs[4] = '{8'h08, 4'h0, 4'h0, 2'd0, 1'b0, 13'd0, 18'h00000, 6'd0, 7'd0};
    vecs[5] = '{8'h07, 4'h1, 4'h1, 2'd1, 1'b0, 13'd0, 18'h00000, 6'd0, 7'd0};
    vecs[6] = '{8'h7E, 4'hF, 4'hF, 2'd3, 1'b1, 13'd0, 18'h3FF7E, 6'd0, 7'd1};
    vecs[7] = '{8'hFF, 4'h0, 4'h0, 2'd0, 1'b1, 13'd1, 18'h000FF, 6'd0, 7'd2};

    // Reset values, then the default power-up screen clear
    repeat (3) tick();
    chk("rst_waddr", 32'(WAddr), 32'd0);
    chk("rst_wdata", 32'(WData), 32'd0);
    chk("rst_write", 32'(Write), 32'd0);
    chk("rst_ready", 32'(ch_ready), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_row", 32'(cursor_row), 32'd0);
    chk("rst_col", 32'(cursor_col), 32'd0);
    push_screen(10'h00F);
    w0 = wcnt;
    rst_n = 1'b1;
    wait_idle(n);
    chk("init_cycles", 32'(n), 32'(CELLS));
    chk("init_writes", 32'(wcnt - w0), 32'(CELLS));
    chk("init_busy", 32'(busy), 32'd0);
    chk("init_ready", 32'(ch_ready), 32'd1);
    chk_cursor("init");

    // Vector table: single characters with exact one/two-cycle timing
    for (int i = 0; i < 8; i++) begin
      send(vecs[i].ch, vecs[i].fg, vecs[i].bg, vecs[i].bl);
      tick();
      chk("vec_ready_n", 32'(ch_ready), 32'(!vecs[i].wr));
      chk("vec_write_n", 32'(Write), 32'd0);
      tick();
      chk("vec_write", 32'(Write), 32'(vecs[i].wr));
      if (vecs[i].wr) begin
        chk("vec_waddr", 32'(WAddr), 32'(vecs[i].addr));
        chk("vec_wdata", 32'(WData), 32'(vecs[i].data));
      end
      chk("vec_ready", 32'(ch_ready), 32'd1);
      chk("vec_row", 32'(cursor_row), 32'(vecs[i].row));
      chk("vec_col", 32'(cursor_col), 32'(vecs[i].col));
    end

    // Line wrap: 'X' in the last column, then row 1 cleared
    send(8'h0D, 4'h0, 4'h0, 2'd0);
    for (int i = 0; i < COLS - 1; i++)
      send(8'(8'h20 + $urandom_range(0, 223)), 4'($urandom), 4'($urandom), 2'($urandom));
    send(8'h58, 4'h5, 4'h6, 2'd2);
    low = 0;
    n = 0;
    do begin
      tick();
      n++;
      if (!ch_ready) low++;
    end while (!ch_ready && n < LIMIT);
    chk("wrap_ready_low", 32'(low), 32'(COLS + 1));
    chk("wrap_pending", 32'(exp_q.size()), 32'd0);
    chk("wrap_row", 32'(cursor_row), 32'd1);
    chk("wrap_col", 32'(cursor_col), 32'd0);

    // Random text, valid held across busy periods
    for (int i = 0; i < 300; i++) begin
      repeat ($urandom_range(0, 2)) tick();
      c = rand_char();
      send(c, 4'($urandom), 4'($urandom), 2'($urandom));
      if (i % 25 == 24) begin
        wait_idle(n);
        chk_cursor("rand");
      end
    end
    wait_idle(n);
    chk_cursor("rand_end");

    // Form feed mid-text with explicit attributes
    send(8'h41, 4'h7, 4'h0, 2'd0);
    send(8'h42, 4'h7, 4'h0, 2'd0);
    wait_idle(n);
    w0 = wcnt;
    send(8'h0C, 4'h2, 4'h4, 2'd1);
    tick();
    tick();
    chk("ff_write", 32'(Write), 32'd1);
    chk("ff_waddr", 32'(WAddr), 32'd0);
    chk("ff_wdata", 32'(WData), 32'h14220);
    chk("ff_busy", 32'(busy), 32'd1);
    wait_idle(n);
    chk("ff_writes", 32'(wcnt - w0), 32'(CELLS));
    chk("ff_row", 32'(cursor_row), 32'd0);
    chk("ff_col", 32'(cursor_col), 32'd0);

    // LF from the last row wraps to row 0 and clears it
    for (int i = 0; i < ROWS - 1; i++) send(8'h0A, 4'($urandom), 4'($urandom), 2'($urandom));
    for (int i = 0; i < 5; i++) send(8'h61, 4'h9, 4'h0, 2'd0);
    wait_idle(n);
    chk("pre_lf_row", 32'(cursor_row), 32'(ROWS - 1));
    chk("pre_lf_col", 32'(cursor_col), 32'd5);
    send(8'h0A, 4'hC, 4'h3, 2'd0);
    tick();
    chk("lf_ready_n", 32'(ch_ready), 32'd0);
    tick();
    chk("lf_write", 32'(Write), 32'd1);
    chk("lf_waddr", 32'(WAddr), 32'd0);
    wait_idle(n);
    chk("lf_row", 32'(cursor_row), 32'd0);
    chk("lf_col", 32'(cursor_col), 32'd0);

    // CR, BEL and BS at column 0: no write, cursor still, ready next cycle
    for (int i = 0; i < 3; i++) begin
      c = (i == 0) ? 8'h0D : (i == 1) ? 8'h07 : 8'h08;
      send(c, 4'h1, 4'h2, 2'd0);
      tick();
      chk("ctl_ready", 32'(ch_ready), 32'd1);
      chk("ctl_write", 32'(Write), 32'd0);
      chk("ctl_row", 32'(cursor_row), 32'd0);
      chk("ctl_col", 32'(cursor_col), 32'd0);
    end

    // Reset in the middle of a line clear
    send(8'h0A, 4'h3, 4'h3, 2'd3);
    repeat (30) tick();
    chk("mid_busy", 32'(busy), 32'd1);
    chk("mid_write", 32'(Write), 32'd1);
    #2 rst_n = 1'b0;
    #1;
    chk("ar_write", 32'(Write), 32'd0);
    chk("ar_waddr", 32'(WAddr), 32'd0);
    chk("ar_wdata", 32'(WData), 32'd0);
    chk("ar_ready", 32'(ch_ready), 32'd0);
    chk("ar_busy", 32'(busy), 32'd0);
    chk("ar_row", 32'(cursor_row), 32'd0);
    chk("ar_col", 32'(cursor_col), 32'd0);
    exp_q.delete();
    mrow = 0;
    mcol = 0;
    repeat (3) tick();
    push_screen(10'h00F);
    w0 = wcnt;
    rst_n = 1'b1;
    wait_idle(n);
    chk("rerun_cycles", 32'(n), 32'(CELLS));
    chk("rerun_writes", 32'(wcnt - w0), 32'(CELLS));
    chk("rerun_busy", 32'(busy), 32'd0);
    chk_cursor("rerun");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
